// File: rtl/edge_config_controller.sv
// Turns four raw board buttons into edits of a shadow configuration set.
// The active outputs copy the shadow only on frame boundaries, so a frame never mixes two settings.
module edge_config_controller #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HOLD_CYCLES     = 12500000,
   parameter int REPEAT_CYCLES   = 2500000
) (
   input  logic       clk25,
   input  logic       rst,
   input  logic       btnUp,
   input  logic       btnDown,
   input  logic       btnSel,
   input  logic       btnDefault,
   input  logic       frameDone,
   output logic [2:0] edgeType,
   output logic       edgeDetectEnable,
   output logic [3:0] cutThresh,
   output logic [3:0] absThresh,
   output logic [3:0] totThresh,
   output logic [3:0] numEdgesNeeded,
   output logic [3:0] sobelKernelThresh,
   output logic [6:0] gradThresh,
   output logic       gradMax,
   output logic       shiftBrightness,
   output logic [3:0] selIndex,
   output logic       pending
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DEBOUNCE = 3'd1;
   localparam logic [2:0] ST_PRESSED  = 3'd2;
   localparam logic [2:0] ST_HELD     = 3'd3;
   localparam logic [2:0] ST_RELEASE  = 3'd4;

   localparam int MAX_A   = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
   localparam int MAX_CYC = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   typedef struct packed {
      logic [2:0] edgeType;
      logic       enable;
      logic [3:0] cut;
      logic [3:0] abs;
      logic [3:0] tot;
      logic [3:0] num;
      logic [3:0] sobel;
      logic [6:0] grad;
      logic       gradMax;
      logic       shift;
   } cfgT;

   localparam cfgT CFG_DEFAULT = '{edgeType: 3'b000, enable: 1'b0, cut: 4'h8, abs: 4'h4,
                                   tot: 4'h6, num: 4'h0, sobel: 4'h3, grad: 7'd32,
                                   gradMax: 1'b0, shift: 1'b1};

   function automatic logic [3:0] step4(input logic [3:0] v, input logic up);
      if (up) return (v == 4'hF) ? v : v + 4'd1;
      return (v == 4'h0) ? v : v - 4'd1;
   endfunction

   function automatic logic [6:0] step7(input logic [6:0] v, input logic up);
      if (up) return (v == 7'd127) ? v : v + 7'd1;
      return (v == 7'd0) ? v : v - 7'd1;
   endfunction

   // Button bit order: 0 Up, 1 Down, 2 Sel, 3 Default.
   logic [3:0] btnRaw;
   logic [3:0] btnMeta;
   logic [3:0] btnSync;
   logic [3:0] btnArmed;
   logic [3:0] btnEvent;

   assign btnRaw = {btnDefault, btnSel, btnDown, btnUp};

   // Synchronizers reset high so a button held through reset is not armed until seen low.
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         btnMeta  <= '1;
         btnSync  <= '1;
         btnArmed <= '0;
      end else begin
         btnMeta  <= btnRaw;
         btnSync  <= btnMeta;
         btnArmed <= btnArmed | ~btnSync;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_btn
         localparam bit CAN_REPEAT = (gi < 2);
         logic [2:0]       state;
         logic [CNT_W-1:0] cnt;
         logic             eventReg;

         assign btnEvent[gi] = eventReg;

         always_ff @(posedge clk25 or posedge rst) begin
            if (rst) begin
               state    <= ST_IDLE;
               cnt      <= '0;
               eventReg <= 1'b0;
            end else begin
               eventReg <= 1'b0;
               case (state)
                  ST_IDLE: begin
                     if (btnSync[gi] && btnArmed[gi]) begin
                        state <= ST_DEBOUNCE;
                        cnt   <= CNT_W'(1);
                     end
                  end
                  ST_DEBOUNCE: begin
                     if (!btnSync[gi]) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                     end else if (cnt >= DEB_LAST) begin
                        state    <= ST_PRESSED;
                        cnt      <= '0;
                        eventReg <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  ST_PRESSED: begin
                     if (!btnSync[gi]) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                     end else if (CAN_REPEAT) begin
                        if (cnt == HOLD_LAST) begin
                           state <= ST_HELD;
                           cnt   <= '0;
                        end else begin
                           cnt <= cnt + 1'b1;
                        end
                     end
                  end
                  ST_HELD: begin
                     if (!btnSync[gi]) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                     end else if (cnt == REP_LAST) begin
                        cnt      <= '0;
                        eventReg <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  ST_RELEASE: begin
                     if (btnSync[gi]) begin
                        cnt <= '0;
                     end else if (cnt >= DEB_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  default: begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end
               endcase
            end
         end
      end
   endgenerate

   logic upEv;
   logic dnEv;
   logic selEv;
   logic defEv;
   assign upEv  = btnEvent[0] & ~btnEvent[1];
   assign dnEv  = btnEvent[1] & ~btnEvent[0];
   assign selEv = btnEvent[2];
   assign defEv = btnEvent[3];

   logic fdMeta;
   logic fdSync;
   logic fdPrev;
   logic commit;
   assign commit = fdSync & ~fdPrev;

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         fdMeta <= 1'b0;
         fdSync <= 1'b0;
         fdPrev <= 1'b0;
      end else begin
         fdMeta <= frameDone;
         fdSync <= fdMeta;
         fdPrev <= fdSync;
      end
   end

   cfgT shadow;
   cfgT active;

   // Edits use the index as it was this cycle; the Sel advance lands alongside.
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         shadow   <= CFG_DEFAULT;
         selIndex <= 4'd0;
      end else if (defEv) begin
         shadow <= CFG_DEFAULT;
      end else begin
         if (upEv || dnEv) begin
            case (selIndex)
               4'd0:    shadow.edgeType <= upEv ? shadow.edgeType + 3'd1 : shadow.edgeType - 3'd1;
               4'd1:    shadow.enable   <= ~shadow.enable;
               4'd2:    shadow.cut      <= step4(shadow.cut, upEv);
               4'd3:    shadow.abs      <= step4(shadow.abs, upEv);
               4'd4:    shadow.tot      <= step4(shadow.tot, upEv);
               4'd5:    shadow.num      <= step4(shadow.num, upEv);
               4'd6:    shadow.sobel    <= step4(shadow.sobel, upEv);
               4'd7:    shadow.grad     <= step7(shadow.grad, upEv);
               4'd8:    shadow.gradMax  <= ~shadow.gradMax;
               4'd9:    shadow.shift    <= ~shadow.shift;
               default: ;
            endcase
         end
         if (selEv) selIndex <= (selIndex == 4'd9) ? 4'd0 : selIndex + 4'd1;
      end
   end

   // Active copy takes the pre-edit shadow when a commit and an edit coincide.
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         active  <= CFG_DEFAULT;
         pending <= 1'b0;
      end else begin
         if (commit) active <= shadow;
         pending <= (shadow != active);
      end
   end

   assign edgeType          = active.edgeType;
   assign edgeDetectEnable  = active.enable;
   assign cutThresh         = active.cut;
   assign absThresh         = active.abs;
   assign totThresh         = active.tot;
   assign numEdgesNeeded    = active.num;
   assign sobelKernelThresh = active.sobel;
   assign gradThresh        = active.grad;
   assign gradMax           = active.gradMax;
   assign shiftBrightness   = active.shift;

endmodule

// File: tb/tb_edge_config_controller.sv
// Directed and randomized bench for edge_config_controller against a field-level model
// of shadow/active configuration built from the editing rules.
module tb_edge_config_controller;

   localparam int D = 4;
   localparam int H = 20;
   localparam int R = 5;

   logic       clk25 = 1'b0;
   logic       rst = 1'b1;
   logic       btnUp = 1'b0;
   logic       btnDown = 1'b0;
   logic       btnSel = 1'b0;
   logic       btnDefault = 1'b0;
   logic       frameDone = 1'b0;
   logic [2:0] edgeType;
   logic       edgeDetectEnable;
   logic [3:0] cutThresh, absThresh, totThresh, numEdgesNeeded, sobelKernelThresh;
   logic [6:0] gradThresh;
   logic       gradMax, shiftBrightness;
   logic [3:0] selIndex;
   logic       pending;

   edge_config_controller #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
      .clk25(clk25), .rst(rst), .btnUp(btnUp), .btnDown(btnDown), .btnSel(btnSel),
      .btnDefault(btnDefault), .frameDone(frameDone), .edgeType(edgeType),
      .edgeDetectEnable(edgeDetectEnable), .cutThresh(cutThresh), .absThresh(absThresh),
      .totThresh(totThresh), .numEdgesNeeded(numEdgesNeeded),
      .sobelKernelThresh(sobelKernelThresh), .gradThresh(gradThresh), .gradMax(gradMax),
      .shiftBrightness(shiftBrightness), .selIndex(selIndex), .pending(pending)
   );

   always #5 clk25 = ~clk25;

   int nAssert = 0;
   int nFail = 0;
   int defs[10] = '{0, 0, 8, 4, 6, 0, 3, 32, 0, 1};
   int mdl[10];
   int act[10];
   int selM = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk25);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] actField(input int f);
      case (f)
         0: return 32'(edgeType);
         1: return 32'(edgeDetectEnable);
         2: return 32'(cutThresh);
         3: return 32'(absThresh);
         4: return 32'(totThresh);
         5: return 32'(numEdgesNeeded);
         6: return 32'(sobelKernelThresh);
         7: return 32'(gradThresh);
         8: return 32'(gradMax);
         default: return 32'(shiftBrightness);
      endcase
   endfunction

   function automatic int anyDiff();
      for (int f = 0; f < 10; f++) if (mdl[f] != act[f]) return 1;
      return 0;
   endfunction

   task automatic checkAll(input string tag);
      for (int f = 0; f < 10; f++) chk($sformatf("%s.field%0d", tag, f), actField(f), act[f]);
      chk({tag, ".selIndex"}, 32'(selIndex), selM);
      chk({tag, ".pending"}, 32'(pending), anyDiff());
   endtask

   task automatic edit(input int dir);
      int f = selM;
      if (f == 0) mdl[0] = (mdl[0] + dir + 8) % 8;
      else if (f == 1 || f == 8 || f == 9) mdl[f] = 1 - mdl[f];
      else begin
         int hi = (f == 7) ? 127 : 15;
         int v = mdl[f] + dir;
         mdl[f] = (v < 0) ? 0 : (v > hi) ? hi : v;
      end
   endtask

   task automatic applyEvent(input int b);
      case (b)
         0: edit(1);
         1: edit(-1);
         2: selM = (selM + 1) % 10;
         default: for (int f = 0; f < 10; f++) mdl[f] = defs[f];
      endcase
   endtask

   task automatic setBtn(input int b, input logic v);
      case (b)
         0: btnUp = v;
         1: btnDown = v;
         2: btnSel = v;
         default: btnDefault = v;
      endcase
   endtask

   // A clean press held for len cycles yields one event once debounced, plus
   // one repeat per full REPEAT period beyond debounce+hold for Up/Down.
   task automatic press(input int b, input int len);
      int ev;
      setBtn(b, 1'b1);
      tick(len);
      setBtn(b, 1'b0);
      tick(D + 6);
      ev = (len >= D) ? 1 : 0;
      if (b < 2 && len >= D + H) ev += (len - D - H) / R;
      for (int k = 0; k < ev; k++) applyEvent(b);
   endtask

   task automatic doCommit();
      frameDone = 1'b1;
      tick(4);
      frameDone = 1'b0;
      tick(4);
      for (int f = 0; f < 10; f++) act[f] = mdl[f];
   endtask

   initial begin
      int need;
      for (int f = 0; f < 10; f++) begin
         mdl[f] = defs[f];
         act[f] = defs[f];
      end

      // Reset, then idle
      tick(3);
      rst = 1'b0;
      tick(50);
      checkAll("reset");

      // Reset asserted while Up is mid-debounce; held on past reset release
      btnUp = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(20);
      btnUp = 1'b0;
      tick(20);
      doCommit();
      checkAll("rstMidPress");

      // Bounced Up on cut: one increment, then exact commit latency
      press(2, 6);
      press(2, 6);
      chk("selAt2", 32'(selIndex), 2);
      btnUp = 1'b1; tick(2);
      btnUp = 1'b0; tick(1);
      btnUp = 1'b1; tick(10);
      btnUp = 1'b0; tick(D + 6);
      applyEvent(0);
      chk("bouncePending", 32'(pending), 1);
      chk("bounceActiveOld", 32'(cutThresh), 8);
      frameDone = 1'b1;
      tick(2);
      chk("commitAt2", 32'(cutThresh), 8);
      tick(1);
      chk("commitAt3", 32'(cutThresh), 9);
      tick(2);
      chk("pendingCleared", 32'(pending), 0);
      frameDone = 1'b0;
      tick(4);
      for (int f = 0; f < 10; f++) act[f] = mdl[f];

      // Clean press: shadow changes exactly D+3 cycles after the raw rise
      btnUp = 1'b1;
      tick(D + 2);
      chk("shadowAtD2", 32'(dut.shadow.cut), 9);
      tick(1);
      chk("shadowAtD3", 32'(dut.shadow.cut), 10);
      tick(5);
      btnUp = 1'b0;
      tick(D + 6);
      applyEvent(0);
      doCommit();
      checkAll("cleanPress");

      // Auto-repeat on gradThresh, then saturation at 127
      for (int i = 0; i < 5; i++) press(2, 6);
      chk("selAt7", 32'(selIndex), 7);
      press(0, 60);
      doCommit();
      checkAll("repeat60");
      need = 126 - mdl[7];
      press(0, D + H + (need - 1) * R);
      doCommit();
      chk("grad126", 32'(gradThresh), 126);
      press(0, 60);
      doCommit();
      chk("grad127", 32'(gradThresh), 127);
      checkAll("gradSat");

      // edgeType wrap both ways, and simultaneous Up/Down
      for (int i = 0; i < 3; i++) press(2, 6);
      press(1, 8);
      doCommit();
      chk("wrapDown", 32'(edgeType), 7);
      press(0, 8);
      doCommit();
      chk("wrapUp", 32'(edgeType), 0);
      btnUp = 1'b1; btnDown = 1'b1;
      tick(8);
      btnUp = 1'b0; btnDown = 1'b0;
      tick(D + 6);
      chk("upDownPending", 32'(pending), 0);
      doCommit();
      checkAll("upDown");

      // Edit and commit on the same edge
      btnUp = 1'b1;
      tick(4);
      frameDone = 1'b1;
      tick(3);
      chk("coincideActive", 32'(edgeType), 0);
      tick(1);
      btnUp = 1'b0;
      frameDone = 1'b0;
      tick(D + 6);
      applyEvent(0);
      chk("coincidePending", 32'(pending), 1);
      doCommit();
      checkAll("coincideNext");

      // Sel ten times wraps back to 0
      for (int i = 1; i <= 10; i++) begin
         press(2, 6);
         chk($sformatf("selStep%0d", i), 32'(selIndex), selM);
      end

      // Edits then Default
      press(2, 6);
      press(2, 6);
      press(1, 40);
      press(3, 8);
      chk("defaultPending", 32'(pending), anyDiff());
      doCommit();
      checkAll("default");

      // Randomized presses and commits
      for (int it = 0; it < 60; it++) begin
         int r = int'($urandom_range(0, 11));
         if (r <= 3) press(0, int'($urandom_range(1, 50)));
         else if (r <= 6) press(1, int'($urandom_range(1, 50)));
         else if (r <= 8) press(2, int'($urandom_range(1, 10)));
         else if (r == 11) press(3, int'($urandom_range(1, 10)));
         if (r >= 9 && r <= 10) begin
            doCommit();
            checkAll($sformatf("rand%0d", it));
         end else begin
            chk($sformatf("rand%0d.pending", it), 32'(pending), anyDiff());
         end
      end
      doCommit();
      checkAll("final");

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/edge_config_controller.md
Name: edge_config_controller

Overview:
- Runtime configuration controller for the edge-detection pixel path: turns four raw board buttons into the mode and threshold settings consumed by the pixel resolver (edgeType, thresholds, numEdgesNeeded, gradThresh, gradMax, shiftBrightness, edgeDetectEnable).
- Edits land in a shadow register set. The active outputs copy the shadow only at frame boundaries, so a displayed frame never mixes two configurations.
- Sits between the board I/O and the resolver, in the clk25 domain.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized samples required to accept a button level change.
- HOLD_CYCLES, 12500000: cycles Up/Down must stay accepted-high before auto-repeat starts.
- REPEAT_CYCLES, 2500000: auto-repeat period once repeating.

Ports:
- clk25  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- btnUp  in  1  raw, asynchronous; increment selected field
- btnDown  in  1  raw, asynchronous; decrement selected field
- btnSel  in  1  raw, asynchronous; advance field index
- btnDefault  in  1  raw, asynchronous; reload shadow with reset values
- frameDone  in  1  asynchronous level; rising edge marks end of frame
- edgeType  out  3  active mode select
- edgeDetectEnable  out  1  active enable
- cutThresh, absThresh, totThresh, numEdgesNeeded, sobelKernelThresh  out  4 each  active thresholds
- gradThresh  out  7  active gradient threshold
- gradMax  out  1  active gradient-max flag
- shiftBrightness  out  1  active dim flag
- selIndex  out  4  currently selected field, for on-screen display
- pending  out  1  high while shadow differs from active

Behaviour:
- Reset (async, rst=1): shadow and active registers both load the defaults: edgeType=3'b000, edgeDetectEnable=0, cut=4'h8, abs=4'h4, tot=4'h6, numEdgesNeeded=4'h0, sobelKernelThresh=4'h3, gradThresh=7'd32, gradMax=0, shiftBrightness=1. Also on reset: selIndex=0, pending=0, all button FSMs in IDLE, debounce and repeat counters at 0. Reset mid-press: the button must be released and re-pressed before any event is generated.
- Synchronization: each button and frameDone passes through a 2-flop synchronizer.
- Button FSM, one per button, states IDLE / DEBOUNCE / PRESSED / HELD / RELEASE:
  - IDLE -> DEBOUNCE on synchronized high.
  - DEBOUNCE counts consecutive highs. A low returns it to IDLE with the count cleared. On reaching DEBOUNCE_CYCLES it goes to PRESSED and issues a 1-cycle event.
  - PRESSED -> HELD after HOLD_CYCLES, Up/Down only. Sel and Default never repeat.
  - HELD issues an event every REPEAT_CYCLES.
  - Any synchronized low in PRESSED or HELD -> RELEASE. RELEASE must see DEBOUNCE_CYCLES consecutive lows to return to IDLE; a high resets that count.
  - Latency: a clean raw press changes the shadow register exactly DEBOUNCE_CYCLES+3 cycles after the raw rise.
- Field map by selIndex:
  - 0 edgeType: wraps 7<->0.
  - 1 edgeDetectEnable, 8 gradMax, 9 shiftBrightness: Up or Down toggles.
  - 2 cut, 3 abs, 4 tot, 5 numEdgesNeeded, 6 sobelKernelThresh: saturate at 0 and 15.
  - 7 gradThresh: saturates at 0 and 127.
- Sel event: selIndex wraps 9 -> 0. Values 10-15 are never produced.
- Event priority, same cycle:
  - Up and Down together: both ignored.
  - Default dominates Up, Down and Sel.
  - Sel together with Up/Down: the value edit applies to the old index, then the index advances.
- Commit:
  - A rising edge of synchronized frameDone produces a commit pulse; the active registers copy the shadow on that edge.
  - Active outputs change exactly 3 cycles after a clean raw frameDone rise and are otherwise stable for the whole frame.
  - Commit and edit in the same cycle: commit takes the pre-edit shadow value, and the edit appears at the next commit.
- pending: registered, equal to (shadow != active). Clears the cycle after commit unless an edit coincided with it.
- Outputs are all registered. No combinational path from any input to any output.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.
- Reset then idle 50 cycles -> all outputs at the listed defaults, selIndex=0, pending=0. Assert rst mid-DEBOUNCE -> no event; outputs stay at defaults.
- selIndex=2, btnUp bounces high 2 cycles / low 1 / high 10 -> exactly one increment: shadow cut 8->9, pending=1, cutThresh still 8. Pulse frameDone -> cutThresh=9 exactly 3 cycles after the raw rise, then pending=0.
- selIndex=7, hold btnUp 60 cycles -> 1 press event plus repeats every 5 cycles after the 20-cycle hold; gradThresh increments by the event count. Starting at 126 -> saturates at 127.
- selIndex=0 with edgeType=7, one Up -> edgeType 0 after commit. btnUp and btnDown accepted the same cycle -> no change.
- Edit event and frameDone commit in the same cycle -> active keeps the old value, pending=1. The next frameDone commits the new value.
- Press Sel 10 times -> selIndex steps 1..9 then wraps to 0. btnDefault after edits -> shadow equals defaults; commit restores default outputs.
